// File: rtl/game_pkg.sv
// game_pkg: setup register map shared by the setup slave and its read initiator.
package game_pkg;
  localparam int SETUP_NUM_REGS = 9;
  localparam int SETUP_ADDR_STEP = 2;
  localparam int SETUP_TIMEOUT_CYCLES = 16;
  localparam logic [7:0] ROW_COLUMN_NUMBER_ADDR = 8'h00;
  localparam logic [7:0] MINE_NUM_ADDR = 8'h02;
  localparam logic [7:0] TIMER_SECONDS_ADDR = 8'h04;
  localparam logic [7:0] FIELD_SIZE_ADDR = 8'h06;
  localparam logic [7:0] BOARD_SIZE_ADDR = 8'h08;
  localparam logic [7:0] BOARD_XPOS_ADDR = 8'h0A;
  localparam logic [7:0] BOARD_YPOS_ADDR = 8'h0C;
  localparam logic [7:0] GAMES_WON_ADDR = 8'h0E;
  localparam logic [7:0] GAMES_LOST_ADDR = 8'h10;
endpackage

// File: rtl/wb_setup_reader.sv
// wb_setup_reader: wishbone master that fetches all setup registers and publishes them atomically.
module wb_setup_reader
  import game_pkg::*;
#(
  parameter int NUM_REGS = SETUP_NUM_REGS,
  parameter int ADDR_STEP = SETUP_ADDR_STEP,
  parameter int TIMEOUT_CYCLES = SETUP_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        stb_o,
  output logic        we_o,
  output logic [7:0]  adr_o,
  input  logic [15:0] dat_i,
  input  logic        ack_i,
  input  logic        stall_i,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] row_column_number,
  output logic [15:0] mine_num,
  output logic [15:0] timer_seconds,
  output logic [15:0] field_size,
  output logic [15:0] board_size,
  output logic [15:0] board_xpos,
  output logic [15:0] board_ypos,
  output logic [15:0] games_won,
  output logic [15:0] games_lost
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, PUBLISH, ERR} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_d;
  logic [3:0] idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0] adr_d;
  logic stb_d, busy_d, done_d, err_d, cap, pub, tmo;
  logic [15:0] shadow [NUM_REGS];
  logic [15:0] pub_r [NUM_REGS];
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign we_o = 1'b0;
  always_comb begin
    state_d = state;
    idx_d = idx;
    cnt_d = cnt;
    adr_d = adr_o;
    stb_d = stb_o;
    busy_d = busy;
    done_d = 1'b0;
    err_d = error;
    cap = 1'b0;
    pub = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = ISSUE;
        idx_d = '0;
        cnt_d = '0;
        adr_d = '0;
        stb_d = 1'b1;
        busy_d = 1'b1;
        err_d = 1'b0;
      end
      ISSUE: if (!stall_i) begin
        state_d = WAIT_ACK;
        stb_d = 1'b0;
        cnt_d = '0;
      end else if (tmo) begin
        state_d = ERR;
        stb_d = 1'b0;
        busy_d = 1'b0;
        err_d = 1'b1;
        cnt_d = '0;
      end else cnt_d = cnt + CW'(1);
      WAIT_ACK: if (ack_i) begin
        cap = 1'b1;
        cnt_d = '0;
        if (idx == 4'(NUM_REGS - 1)) begin
          state_d = PUBLISH;
          busy_d = 1'b0;
          done_d = 1'b1;
          pub = 1'b1;
        end else begin
          state_d = ISSUE;
          idx_d = idx + 4'd1;
          adr_d = 8'((int'(idx) + 1) * ADDR_STEP);
          stb_d = 1'b1;
        end
      end else if (tmo) begin
        state_d = ERR;
        busy_d = 1'b0;
        err_d = 1'b1;
        cnt_d = '0;
      end else cnt_d = cnt + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  // the final word goes straight from the bus into the published set so all nine update together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      adr_o <= '0;
      stb_o <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        pub_r[i] <= '0;
      end
    end else begin
      state <= state_d;
      idx <= idx_d;
      cnt <= cnt_d;
      adr_o <= adr_d;
      stb_o <= stb_d;
      busy <= busy_d;
      done <= done_d;
      error <= err_d;
      if (cap) shadow[idx] <= dat_i;
      if (pub) for (int i = 0; i < NUM_REGS; i++) pub_r[i] <= (i == int'(idx)) ? dat_i : shadow[i];
    end
  end
  assign row_column_number = pub_r[0];
  assign mine_num = pub_r[1];
  assign timer_seconds = pub_r[2];
  assign field_size = pub_r[3];
  assign board_size = pub_r[4];
  assign board_xpos = pub_r[5];
  assign board_ypos = pub_r[6];
  assign games_won = pub_r[7];
  assign games_lost = pub_r[8];
endmodule

// File: tb/tb_wb_setup_reader.sv
// tb_wb_setup_reader: bench with a scripted wishbone slave and a cycle-count reference model.
module tb_wb_setup_reader;
  logic clk = 0, rst = 0, start = 0, ack_i = 0, stall_i = 0;
  logic stb_o, we_o, busy, done, error;
  logic [7:0] adr_o;
  logic [15:0] dat_i = 0;
  logic [15:0] o [9];
  logic [15:0] mem [9];
  logic [15:0] pub_m [9];
  int stall_t [9];
  int dly_t [9];
  int total = 0, bad = 0;
  typedef struct {int sk; int sn; int dk; int dn; int s2; bit err;} vec_t;
  vec_t vecs [10];

  wb_setup_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_i(dat_i), .ack_i(ack_i), .stall_i(stall_i),
    .busy(busy), .done(done), .error(error),
    .row_column_number(o[0]), .mine_num(o[1]), .timer_seconds(o[2]),
    .field_size(o[3]), .board_size(o[4]), .board_xpos(o[5]), .board_ypos(o[6]),
    .games_won(o[7]), .games_lost(o[8])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // cycle 1 issues register 0; each register costs stall + accept + ack latency
  function automatic void model(output int fin, output int reads, output bit err);
    int c;
    c = 1;
    fin = 0;
    reads = 0;
    err = 0;
    for (int k = 0; k < 9; k++) begin
      if (stall_t[k] >= 16) begin
        fin = c + 16;
        err = 1;
        return;
      end
      reads++;
      if (dly_t[k] >= 16) begin
        fin = c + stall_t[k] + 1 + 16;
        err = 1;
        return;
      end
      c += stall_t[k] + 2 + dly_t[k];
    end
    fin = c;
  endfunction

  task automatic fetch(input int s2, input bit exp_err, input int rst_at);
    int fin, ereads, reads, nbusy, ndone, dcyc, early, used, ack_at, ack_k, k, diff, nstb;
    bit merr;
    logic [15:0] ev;
    model(fin, ereads, merr);
    reads = 0; nbusy = 0; ndone = 0; dcyc = 0; early = 0; used = 0; ack_at = -1; ack_k = 0;
    @(negedge clk);
    start = 1;
    for (int n = 1; n <= fin + 4; n++) begin
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        ev = (n >= fin && !exp_err) ? mem[i] : pub_m[i];
        if (o[i] != ev) early++;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) dcyc = n;
      end
      if (busy) nbusy++;
      if (n == 1) chk("err_clear", int'(error), 0);
      if (n == fin) begin
        chk("end_done", int'(done), int'(!exp_err));
        chk("end_error", int'(error), int'(exp_err));
        chk("end_stb", int'(stb_o), 0);
      end
      if (n == rst_at) begin
        chk("pre_rst_stb", int'(stb_o), 1);
        #2 rst = 0;
        #1;
        chk("rst_stb", int'(stb_o), 0);
        chk("rst_adr", int'(adr_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_error", int'(error), 0);
        diff = 0;
        for (int i = 0; i < 9; i++) if (o[i] != 0) diff++;
        chk("rst_regs", diff, 0);
        start = 0; ack_i = 0; stall_i = 0;
        @(negedge clk);
        rst = 1;
        ndone = 0; nstb = 0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          if (done) ndone++;
          if (stb_o) nstb++;
        end
        chk("rst_no_done", ndone, 0);
        chk("rst_no_stb", nstb, 0);
        for (int i = 0; i < 9; i++) pub_m[i] = 0;
        return;
      end
      start = (n == s2);
      ack_i = (n == ack_at);
      dat_i = ack_i ? mem[ack_k] : 16'hBEEF;
      stall_i = 0;
      if (stb_o) begin
        k = int'(adr_o) >> 1;
        if (k > 8) k = 8;
        if (used < stall_t[k]) begin
          stall_i = 1;
          used++;
        end else begin
          used = 0;
          chk("adr", int'(adr_o), reads * 2);
          chk("we", int'(we_o), 0);
          reads++;
          ack_k = k;
          ack_at = dly_t[k] >= 16 ? -1 : n + 1 + dly_t[k];
        end
      end
    end
    start = 0; ack_i = 0; stall_i = 0;
    chk("reads", reads, ereads);
    chk("busy_cycles", nbusy, fin - 1);
    chk("done_pulses", ndone, exp_err ? 0 : 1);
    chk("done_cycle", dcyc, exp_err ? 0 : fin);
    chk("pub_track", early, 0);
    if (!exp_err) for (int i = 0; i < 9; i++) pub_m[i] = mem[i];
    for (int i = 0; i < 9; i++) chk($sformatf("reg%0d", i), int'(o[i]), int'(pub_m[i]));
  endtask

  task automatic clear_profile();
    for (int i = 0; i < 9; i++) begin
      stall_t[i] = 0;
      dly_t[i] = 0;
    end
  endtask

  initial begin
    mem = '{16'h0909, 16'd10, 16'd999, 16'd81, 16'd288, 16'd176, 16'd96, 16'd0, 16'd3};
    for (int i = 0; i < 9; i++) pub_m[i] = 0;
    vecs[0] = '{-1, 0, -1, 0, -1, 0};
    vecs[1] = '{2, 3, -1, 0, -1, 0};
    vecs[2] = '{8, 15, -1, 0, -1, 0};
    vecs[3] = '{4, 16, -1, 0, -1, 1};
    vecs[4] = '{-1, 0, 3, 99, -1, 1};
    vecs[5] = '{-1, 0, 0, 15, -1, 0};
    vecs[6] = '{-1, 0, 8, 16, -1, 1};
    vecs[7] = '{-1, 0, -1, 0, 5, 0};
    vecs[8] = '{-1, 0, -1, 0, 19, 0};
    vecs[9] = '{-1, 0, 1, 99, 20, 1};
    #12;
    chk("reset_stb", int'(stb_o), 0);
    chk("reset_we", int'(we_o), 0);
    chk("reset_adr", int'(adr_o), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    for (int i = 0; i < 9; i++) chk($sformatf("reset_reg%0d", i), int'(o[i]), 0);
    @(negedge clk);
    rst = 1;
    for (int v = 0; v < 10; v++) begin
      clear_profile();
      if (vecs[v].sk >= 0) stall_t[vecs[v].sk] = vecs[v].sn;
      if (vecs[v].dk >= 0) dly_t[vecs[v].dk] = vecs[v].dn;
      fetch(vecs[v].s2, vecs[v].err, -1);
      if (v == 0) mem[7] = 16'd1;
    end
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 9; i++) begin
        mem[i] = ($urandom_range(0, 5) == 0) ? 16'hDEAD : 16'($urandom);
        stall_t[i] = int'($urandom_range(0, 3));
        dly_t[i] = int'($urandom_range(0, 3));
      end
      fetch(-1, 0, -1);
    end
    clear_profile();
    fetch(-1, 0, 7);
    fetch(-1, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
